// File: rtl/alu_exec_pkg.sv
// Shared definitions for the ALU execution unit.
// Contents: default operand width, one-hot op bit indices and the FSM state type.
package alu_exec_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int NUM_OPS       = 15;

    localparam int OP_ADD  = 0;
    localparam int OP_SUB  = 1;
    localparam int OP_MUL  = 2;
    localparam int OP_DIV  = 3;
    localparam int OP_MOD  = 4;
    localparam int OP_MAX  = 5;
    localparam int OP_MIN  = 6;
    localparam int OP_NOT  = 7;
    localparam int OP_NAND = 8;
    localparam int OP_XNOR = 9;
    localparam int OP_SHL  = 10;
    localparam int OP_SHRL = 11;
    localparam int OP_ROL  = 12;
    localparam int OP_ROR  = 13;
    localparam int OP_SLT  = 14;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULT = 2'd1,
        ST_DIVD = 2'd2,
        ST_DONE = 2'd3
    } alu_state_e;

endpackage

// File: rtl/alu_exec_unit_if.sv
// Handshake/data bundle between the core sequencer and the ALU execution unit.
// master: sequencer side (drives start, op, a, b; receives result and status).
// slave : execution unit side.
interface alu_exec_unit_if #(
    parameter int WIDTH = alu_exec_pkg::DEFAULT_WIDTH
);
    logic                              start;
    logic [alu_exec_pkg::NUM_OPS-1:0]  op;
    logic [WIDTH-1:0]                  a;
    logic [WIDTH-1:0]                  b;
    logic [WIDTH-1:0]                  result;
    logic                              busy;
    logic                              done;
    logic                              zero;
    logic                              carry;
    logic                              ovf;
    logic                              dbz;
    logic                              err;

    modport master (
        output start, op, a, b,
        input  result, busy, done, zero, carry, ovf, dbz, err
    );

    modport slave (
        input  start, op, a, b,
        output result, busy, done, zero, carry, ovf, dbz, err
    );
endinterface

// File: rtl/alu_iter_divider.sv
// Unsigned restoring divider, one quotient bit per clock.
// Ports: clk, rst (sync, active-high), start (load pulse, ignored while busy),
//        dividend/divisor (sampled on start), busy, done (one-cycle pulse),
//        quotient/remainder (valid with done, held until the next start).
// The first iteration is performed on the load edge, so done appears WIDTH
// cycles after start; divisor must be nonzero (the caller handles zero).
module alu_iter_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] src_rem;
    logic [WIDTH-1:0] src_quo;
    logic [WIDTH-1:0] src_dvs;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo_nxt;
    logic [WIDTH:0]   partial;
    logic [WIDTH:0]   trial;
    logic [SHW-1:0]   cnt;

    // quotient doubles as the dividend shift register: dividend bits leave
    // at the top while quotient bits enter at the bottom.
    always_comb begin
        src_rem = busy ? remainder : '0;
        src_quo = busy ? quotient  : dividend;
        src_dvs = busy ? dvs       : divisor;
        partial = {src_rem, src_quo[WIDTH-1]};
        trial   = partial - {1'b0, src_dvs};
        if (trial[WIDTH]) begin
            rem_nxt = partial[WIDTH-1:0];
            quo_nxt = {src_quo[WIDTH-2:0], 1'b0};
        end else begin
            rem_nxt = trial[WIDTH-1:0];
            quo_nxt = {src_quo[WIDTH-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            dvs       <= '0;
            cnt       <= '0;
        end else begin
            done <= 1'b0;
            if (busy) begin
                remainder <= rem_nxt;
                quotient  <= quo_nxt;
                cnt       <= cnt - SHW'(1);
                if (cnt == SHW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end else if (start) begin
                remainder <= rem_nxt;
                quotient  <= quo_nxt;
                dvs       <= divisor;
                cnt       <= SHW'(WIDTH - 1);
                busy      <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: one-hot op in, registered result + status flags out.
// Ports: clk, rst (sync, active-high), bus (alu_exec_unit_if.slave:
//        start/op/a/b in; result/busy/done/zero/carry/ovf/dbz/err out).
// Single-cycle ops finish one cycle after start; MUL (shift-add) and
// DIV/MOD (alu_iter_divider) finish WIDTH+1 cycles after start.
// Build option: define ALU_EARLY_TERM_EN to let MUL stop once the remaining
// multiplier bits are zero (at least one iteration is always performed).
//
// state   | meaning
// --------+------------------------------------------------
// ST_IDLE | waiting for start; single-cycle ops resolve here
// ST_MULT | shift-add multiply, one multiplier bit per cycle
// ST_DIVD | waiting for the iterative divider
// ST_DONE | done pulse cycle, then back to idle
module alu_exec_unit
    import alu_exec_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic            clk,
    input  logic            rst,
    alu_exec_unit_if.slave  bus
);
    localparam int SHW = $clog2(WIDTH);

    alu_state_e         state;
    logic [SHW-1:0]     mul_cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0]   mplier;
    logic               mul_last;
    logic               is_mod;

    logic               div_start;
    logic               div_busy;
    logic               div_done;
    logic [WIDTH-1:0]   div_quo;
    logic [WIDTH-1:0]   div_rem;

    logic [WIDTH-1:0]   sc_result;
    logic               sc_carry;
    logic               sc_dbz;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [SHW-1:0]     amt;
    logic [SHW:0]       amt_inv;
    logic               slt;

    assign div_start = (state == ST_IDLE) && bus.start && $onehot(bus.op) &&
                       (bus.op[OP_DIV] || bus.op[OP_MOD]) &&
                       (bus.b != '0) && !div_busy;

    alu_iter_divider #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .dividend  (bus.a),
        .divisor   (bus.b),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    assign acc_nxt = acc + (mplier[0] ? mcand : '0);

`ifdef ALU_EARLY_TERM_EN
    assign mul_last = (mul_cnt == '0) || (mplier[WIDTH-1:1] == '0);
`else
    assign mul_last = (mul_cnt == '0);
`endif

    // Rotates are built from two logical shifts; amt_inv == WIDTH when
    // amt == 0, which shifts the second term fully out and leaves a intact.
    assign amt     = bus.b[SHW-1:0];
    assign amt_inv = (SHW+1)'(WIDTH) - {1'b0, amt};
    assign slt     = $signed(bus.a) < $signed(bus.b);

    // DIV/MOD only take this path with b == 0.
    always_comb begin
        sum       = {1'b0, bus.a} + {1'b0, bus.b};
        diff      = {1'b0, bus.a} - {1'b0, bus.b};
        sc_result = '0;
        sc_carry  = 1'b0;
        sc_dbz    = 1'b0;
        if (bus.op[OP_ADD]) begin
            sc_result = sum[WIDTH-1:0];
            sc_carry  = sum[WIDTH];
        end else if (bus.op[OP_SUB]) begin
            sc_result = diff[WIDTH-1:0];
            sc_carry  = diff[WIDTH];
        end else if (bus.op[OP_DIV]) begin
            sc_result = '1;
            sc_dbz    = (bus.b == '0);
        end else if (bus.op[OP_MOD]) begin
            sc_result = bus.a;
            sc_dbz    = (bus.b == '0);
        end else if (bus.op[OP_MAX]) begin
            sc_result = slt ? bus.b : bus.a;
        end else if (bus.op[OP_MIN]) begin
            sc_result = slt ? bus.a : bus.b;
        end else if (bus.op[OP_NOT]) begin
            sc_result = ~bus.a;
        end else if (bus.op[OP_NAND]) begin
            sc_result = ~(bus.a & bus.b);
        end else if (bus.op[OP_XNOR]) begin
            sc_result = ~(bus.a ^ bus.b);
        end else if (bus.op[OP_SHL]) begin
            sc_result = bus.a << amt;
        end else if (bus.op[OP_SHRL]) begin
            sc_result = bus.a >> amt;
        end else if (bus.op[OP_ROL]) begin
            sc_result = (bus.a << amt) | (bus.a >> amt_inv);
        end else if (bus.op[OP_ROR]) begin
            sc_result = (bus.a >> amt) | (bus.a << amt_inv);
        end else if (bus.op[OP_SLT]) begin
            sc_result = {{(WIDTH-1){1'b0}}, slt};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            mul_cnt    <= '0;
            acc        <= '0;
            mcand      <= '0;
            mplier     <= '0;
            is_mod     <= 1'b0;
            bus.result <= '0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.zero   <= 1'b0;
            bus.carry  <= 1'b0;
            bus.ovf    <= 1'b0;
            bus.dbz    <= 1'b0;
            bus.err    <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        bus.busy  <= 1'b1;
                        bus.zero  <= 1'b0;
                        bus.carry <= 1'b0;
                        bus.ovf   <= 1'b0;
                        bus.dbz   <= 1'b0;
                        bus.err   <= 1'b0;
                        is_mod    <= bus.op[OP_MOD];
                        if (!$onehot(bus.op)) begin
                            bus.err    <= 1'b1;
                            bus.result <= '0;
                            bus.zero   <= 1'b1;
                            bus.done   <= 1'b1;
                            state      <= ST_DONE;
                        end else if (bus.op[OP_MUL]) begin
                            acc     <= '0;
                            mcand   <= {{WIDTH{1'b0}}, bus.a};
                            mplier  <= bus.b;
                            mul_cnt <= SHW'(WIDTH - 1);
                            state   <= ST_MULT;
                        end else if (div_start) begin
                            state <= ST_DIVD;
                        end else begin
                            bus.result <= sc_result;
                            bus.carry  <= sc_carry;
                            bus.dbz    <= sc_dbz;
                            bus.zero   <= (sc_result == '0);
                            bus.done   <= 1'b1;
                            state      <= ST_DONE;
                        end
                    end
                end
                ST_MULT: begin
                    acc     <= acc_nxt;
                    mcand   <= mcand << 1;
                    mplier  <= mplier >> 1;
                    mul_cnt <= mul_cnt - SHW'(1);
                    if (mul_last) begin
                        bus.result <= acc_nxt[WIDTH-1:0];
                        bus.ovf    <= |acc_nxt[2*WIDTH-1:WIDTH];
                        bus.zero   <= (acc_nxt[WIDTH-1:0] == '0);
                        bus.done   <= 1'b1;
                        state      <= ST_DONE;
                    end
                end
                ST_DIVD: begin
                    if (div_done) begin
                        bus.result <= is_mod ? div_rem : div_quo;
                        bus.zero   <= ((is_mod ? div_rem : div_quo) == '0);
                        bus.done   <= 1'b1;
                        state      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    bus.busy <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
Execution datapath driven by the one-hot ALU control strobes that the opcode decoder produces. It latches operands and the one-hot op on a start pulse. Single-cycle ops complete in 1 cycle; MUL, DIV and MOD run iteratively over WIDTH cycles. It returns the result, status flags and a one-cycle done pulse to the core sequencer.

Parameters:
WIDTH, 16, operand/result width in bits (power of 2, >=4)
SHW, $clog2(WIDTH), shift-amount width (derived; not overridden)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
start  in  1  launch pulse; sampled only in IDLE
op  in  15  one-hot op, bit order [0]ADD [1]SUB [2]MUL [3]DIV [4]MOD [5]MAX [6]MIN [7]NOT [8]NAND [9]XNOR [10]SHL [11]SHRL [12]ROL [13]ROR [14]SLT
a  in  WIDTH  operand A
b  in  WIDTH  operand B (shift/rotate amount = b[SHW-1:0])
result  out  WIDTH  registered result, held until next accepted start
busy  out  1  high while state != IDLE
done  out  1  one-cycle pulse when result/flags valid
zero  out  1  result == 0
carry  out  1  ADD carry-out / SUB borrow; 0 otherwise
ovf  out  1  MUL upper half nonzero; 0 otherwise
dbz  out  1  DIV/MOD with b == 0
err  out  1  op not exactly one-hot at start

Behaviour:
- Reset: state=IDLE; result, busy, done and all flags = 0. Reset mid-operation aborts with no done pulse.
- States: IDLE, MULT, DIVD, DONE.
  - IDLE + start: latch a, b, op. If op is not one-hot -> err=1, result=0, go DONE. If MUL -> MULT. If DIV/MOD with b!=0 -> DIVD. Otherwise compute in the same cycle -> DONE.
  - MULT: WIDTH shift-add iterations, then DONE.
  - DIVD: WIDTH restoring-division iterations, then DONE.
  - DONE: done=1 for one cycle, then IDLE.
- Latency (start cycle = 0): single-cycle ops, error and divide-by-zero give done at cycle 1. MUL/DIV/MOD give done at cycle WIDTH+1.
- start is ignored while busy. start in the cycle of IDLE return is accepted.
- Flags are cleared on every accepted start and updated together with result. zero is computed on the final result.
- Arithmetic:
  - ADD/SUB/MUL/DIV/MOD are unsigned, results truncated to WIDTH.
  - MUL keeps the low WIDTH bits; ovf = |high WIDTH bits.
  - DIV by 0: result=all ones, dbz=1. MOD by 0: result=a, dbz=1.
  - MAX, MIN and SLT are signed two's complement. SLT result is 1 or 0, zero-extended.
  - NOT = ~a; NAND = ~(a&b); XNOR = ~(a^b).
  - SHL/SHRL are logical with zero fill. ROL/ROR rotate by b[SHW-1:0]. Amount 0 gives a unchanged.

Optional Feature:
ALU_EARLY_TERM_EN
- Defined: MULT exits to DONE as soon as the remaining multiplier bits are all zero. Minimum is 1 iteration, so MUL by 0 or 1 completes at cycle 2. Result and flags are identical to the full run.
- Undefined: MUL always takes exactly WIDTH iterations, fixed latency WIDTH+1.
- DIV/MOD are unaffected either way.

Decomposition:
- Package alu_exec_pkg:
  - op bit-index localparams (OP_ADD=0 … OP_SLT=14), NUM_OPS=15
  - state enum
  - default WIDTH
- Sub-module alu_iter_divider: restoring divider with start/busy/done; outputs quotient and remainder.
- MUL loop and single-cycle ops stay in the top module.

Test Plan (WIDTH=16):
1. ADD a=0xFFFF b=0x0001 -> result 0x0000, carry=1, zero=1, done at cycle 1. SUB a=0x0003 b=0x0005 -> 0xFFFE, carry=1.
2. MUL a=300 b=300 -> result 0x5F90, ovf=1, done at cycle 17 (feature off). With ALU_EARLY_TERM_EN: MUL a=5 b=1 -> 0x0005, done at cycle 2.
3. DIV a=100 b=7 -> 0x000E, done cycle 17. MOD a=100 b=7 -> 0x0002. DIV a=9 b=0 -> 0xFFFF, dbz=1, done cycle 1. MOD a=9 b=0 -> 0x0009, dbz=1.
4. Signed/shift ops with a=0xFFFF, b=0x0001: SLT -> 0x0001, MAX -> 0x0001, MIN -> 0xFFFF. Rotates: ROL a=0x8001 b=1 -> 0x0003; ROR a=0x0001 b=4 -> 0x1000. SHRL a=0x8000 b=15 -> 0x0001.
5. op=0 -> err=1, result 0, done at cycle 1. op=0x0003 -> err=1, result 0.
6. Start MUL, assert start+ADD at cycle 3 -> ignored, MUL result unchanged. Assert rst at cycle 5 of another MUL -> busy=0 and all outputs 0 next cycle, no done pulse.
